// File: rtl/doa_report_csr.sv
// Direction-of-arrival result queue: captures {seq, maxbin, doa} on done into a
// small FIFO and exposes it over an Avalon-MM slave with read-to-pop and a level irq.
module doa_report_csr #(
  parameter int DEPTH = 8,
  parameter int DROPW = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        done,
  input  logic [7:0]  doa,
  input  logic [9:0]  maxbin,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]      mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [7:0]       seq_r;
  logic [DROPW-1:0] drop_cnt_r;
  logic             ovf_r, ien_r;
  logic [31:0]      readdata_r;
  logic             irq_r;

  logic             rd_s, ctrl_wr_s, flush_s, clear_s;
  logic             full_s, empty_s, pop_s, push_s, drop_s;
  logic [CW-1:0]    count_nxt_s;
  logic [DROPW-1:0] drop_cnt_nxt_s;
  logic             ovf_nxt_s, ien_nxt_s;
  logic [31:0]      entry_s, rdmux_s;

  // Decode bus strobes and resolve push/pop/flush/clear for this cycle.
  always_comb begin
    rd_s      = chipselect & read;
    ctrl_wr_s = chipselect & write & (address == 2'd2);
    flush_s   = ctrl_wr_s & writedata[2];
    clear_s   = ctrl_wr_s & writedata[1];
    full_s    = (count_r == CW'(DEPTH));
    empty_s   = (count_r == {CW{1'b0}});
    pop_s     = rd_s & (address == 2'd1) & ~empty_s;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    push_s    = done & ~flush_s & (~full_s | pop_s);
    drop_s    = done & ~flush_s & full_s & ~pop_s;
    entry_s   = {seq_r, maxbin, 6'b000000, doa};

    if (flush_s) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      count_nxt_s = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};
    end

    if (clear_s) begin
      ovf_nxt_s      = 1'b0;
      drop_cnt_nxt_s = {DROPW{1'b0}};
    end else if (drop_s) begin
      ovf_nxt_s      = 1'b1;
      drop_cnt_nxt_s = (drop_cnt_r == {DROPW{1'b1}}) ? drop_cnt_r
                                                      : drop_cnt_r + {{(DROPW-1){1'b0}}, 1'b1};
    end else begin
      ovf_nxt_s      = ovf_r;
      drop_cnt_nxt_s = drop_cnt_r;
    end

    if (ctrl_wr_s) begin
      ien_nxt_s = writedata[0];
    end else begin
      ien_nxt_s = ien_r;
    end
  end

  // Read data multiplexer; unmapped bits stay zero.
  always_comb begin
    rdmux_s = 32'h0000_0000;
    case (address)
      2'd0: begin
        rdmux_s[CW-1:0] = count_r;
        rdmux_s[8]      = empty_s;
        rdmux_s[9]      = full_s;
        rdmux_s[10]     = ovf_r;
        rdmux_s[16]     = ien_r;
      end
      2'd1: begin
        if (empty_s) begin
          rdmux_s = 32'h0000_0000;
        end else begin
          rdmux_s = mem_r[rd_ptr_r];
        end
      end
      2'd2:    rdmux_s[0] = ien_r;
      2'd3:    rdmux_s[DROPW-1:0] = drop_cnt_r;
      default: rdmux_s = 32'h0000_0000;
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // Control state, pointers, registered read data and interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      seq_r      <= 8'd0;
      drop_cnt_r <= {DROPW{1'b0}};
      ovf_r      <= 1'b0;
      ien_r      <= 1'b0;
      readdata_r <= 32'h0000_0000;
      irq_r      <= 1'b0;
    end else begin
      if (flush_s) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        wr_ptr_r <= push_s ? wr_ptr_r + {{(AW-1){1'b0}}, 1'b1} : wr_ptr_r;
        rd_ptr_r <= pop_s  ? rd_ptr_r + {{(AW-1){1'b0}}, 1'b1} : rd_ptr_r;
      end
      count_r    <= count_nxt_s;
      seq_r      <= done ? seq_r + 8'd1 : seq_r;
      drop_cnt_r <= drop_cnt_nxt_s;
      ovf_r      <= ovf_nxt_s;
      ien_r      <= ien_nxt_s;
      readdata_r <= rd_s ? rdmux_s : readdata_r;
      irq_r      <= ien_nxt_s & ((count_nxt_s != {CW{1'b0}}) | ovf_nxt_s);
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;

endmodule
